// File: rtl/fpu_half_pkg.sv
// Shared definitions for the half-precision FPU front end: opcodes,
// arbiter state encoding and the abort result constants.
package fpu_half_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_SQRT = 3'd4
  } fpu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_e;

  // Result returned when the FPU never answers: default quiet NaN, invalid flag.
  localparam logic [15:0] QNAN_H  = 16'h7E00;
  localparam logic [4:0]  FLAG_NV = 5'b10000;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a single priority bit picks the winner when
// both requesters are valid; it moves to the non-owner after each response.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       upd,
  input  logic       upd_owner,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  logic prio;

  // Priority bit: requester 0 favoured after reset, then the non-owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (upd) begin
      prio <= ~upd_owner;
    end
  end

  // One-hot grant; a lone requester wins regardless of priority.
  always_comb begin
    gnt     = '0;
    gnt_idx = 1'b0;
    if (en) begin
      case (req)
        2'b01: begin
          gnt     = 2'b01;
          gnt_idx = 1'b0;
        end
        2'b10: begin
          gnt     = 2'b10;
          gnt_idx = 1'b1;
        end
        2'b11: begin
          gnt     = prio ? 2'b10 : 2'b01;
          gnt_idx = prio;
        end
        default: begin
          gnt     = '0;
          gnt_idx = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fpu_half_arbiter.sv
// Shares one half-precision FPU between two requesters. One operation is in
// flight at a time; the FPU is aborted with a qNaN result after TIMEOUT cycles.
module fpu_half_arbiter
  import fpu_half_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [15:0] rsp_result,
  output logic [4:0]  rsp_flags,
  output logic        fpu_start,
  output logic [2:0]  fpu_op,
  output logic [15:0] fpu_a,
  output logic [15:0] fpu_b,
  input  logic        fpu_done,
  input  logic [15:0] fpu_result,
  input  logic [4:0]  fpu_flags,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  arb_state_e    state, state_nxt;
  logic          owner;
  logic [2:0]    op_q;
  logic [15:0]   a_q, b_q;
  logic [CW-1:0] cnt;
  logic [15:0]   res_q;
  logic [4:0]    flg_q;
  logic          terr_q;

  logic [1:0]    gnt;
  logic          gnt_idx;
  logic          grant;
  logic          timeout_hit;
  logic          rsp_done;

  rr_arb2 u_rr_arb2 (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .req       (req_valid),
    .en        ((state == ST_IDLE) && !wb_rst_i),
    .upd       (rsp_done),
    .upd_owner (owner),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx)
  );

  assign grant       = |gnt;
  assign timeout_hit = (state == ST_WAIT) && !fpu_done && (cnt == CW'(TIMEOUT - 1));
  assign rsp_done    = (state == ST_RESP) && rsp_ready[owner];

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; all forced low while reset is held.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    fpu_start = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE:  if (grant) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (fpu_done || timeout_hit) state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready[owner]) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (!wb_rst_i) begin
      req_ready = gnt;
      rsp_valid = (state == ST_RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
      fpu_start = (state == ST_ISSUE);
      busy      = (state != ST_IDLE);
    end
  end

  // Capture the granted requester's operation; held until the next grant.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      owner <= 1'b0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (grant) begin
      owner <= gnt_idx;
      op_q  <= gnt_idx ? req_op[5:3]  : req_op[2:0];
      a_q   <= gnt_idx ? req_a[31:16] : req_a[15:0];
      b_q   <= gnt_idx ? req_b[31:16] : req_b[15:0];
    end
  end

  // Wait-cycle counter: cleared in ISSUE, counts WAIT cycles without done.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt <= '0;
    end else if (state == ST_ISSUE) begin
      cnt <= '0;
    end else if ((state == ST_WAIT) && !fpu_done && !timeout_hit) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Result capture from the FPU or the abort path; timeout flag is sticky.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      res_q  <= '0;
      flg_q  <= '0;
      terr_q <= 1'b0;
    end else if ((state == ST_WAIT) && fpu_done) begin
      res_q <= fpu_result;
      flg_q <= fpu_flags;
    end else if (timeout_hit) begin
      res_q  <= QNAN_H;
      flg_q  <= FLAG_NV;
      terr_q <= 1'b1;
    end
  end

  assign fpu_op      = op_q;
  assign fpu_a       = a_q;
  assign fpu_b       = b_q;
  assign rsp_result  = res_q;
  assign rsp_flags   = flg_q;
  assign timeout_err = terr_q;

endmodule
